// File: rtl/riscv_encode_pkg.sv
// Shared types and constants for the RV32I instruction encoder.
package riscv_encode_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } enc_state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam int FIFO_DEPTH_DEFAULT = 4;
    localparam int FIFO_WIDTH         = 64;

endpackage

// File: rtl/encoder_fifo.sv
// Word+address buffer between the encoder and the downstream consumer.
module encoder_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    // Extra pointer bit distinguishes full from empty when the indices match.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    assign rdata = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/instruction_encoder.sv
// Packs RV32I field bundles into instruction words, range-checks immediates,
// and streams words with their byte addresses through a small FIFO.
//
//   state    | meaning
//   IDLE     | waiting for start
//   LOAD     | accepting bundles until one marked last
//   DRAIN    | waiting for buffered words to leave
//   DONE     | single-cycle done pulse
module instruction_encoder
    import riscv_encode_pkg::*;
#(
    parameter int          FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_last,
    input  logic [2:0]  in_fmt,
    input  logic [6:0]  in_opcode,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_func3,
    input  logic [6:0]  in_func7,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        enc_error,
    output logic        done,
    output logic [31:0] instr_count
);

    enc_state_e        state;
    logic [31:0]       addr;
    logic [31:0]       word;
    logic              imm_ok;
    logic              accept;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [63:0]       fifo_rdata;
    logic signed [31:0] imm_s;

    assign imm_s = $signed(in_imm);

    always_comb begin
        word   = '0;
        imm_ok = 1'b0;
        case (in_fmt)
            FMT_R: begin
                word   = {in_func7, in_rs2, in_rs1, in_func3, in_rd, in_opcode};
                imm_ok = 1'b1;
            end
            FMT_I: begin
                word   = {in_imm[11:0], in_rs1, in_func3, in_rd, in_opcode};
                imm_ok = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
            end
            FMT_S: begin
                word   = {in_imm[11:5], in_rs2, in_rs1, in_func3, in_imm[4:0], in_opcode};
                imm_ok = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
            end
            FMT_B: begin
                word   = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_func3,
                          in_imm[4:1], in_imm[11], in_opcode};
                imm_ok = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094) && !in_imm[0];
            end
            FMT_U: begin
                word   = {in_imm[31:12], in_rd, in_opcode};
                imm_ok = (in_imm[11:0] == 12'd0);
            end
            FMT_J: begin
                word   = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
                imm_ok = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574) && !in_imm[0];
            end
            default: begin
                word   = '0;
                imm_ok = 1'b0;
            end
        endcase
    end

    assign in_ready  = (state == ST_LOAD) && !fifo_full;
    assign accept    = in_valid && in_ready;
    assign push      = accept && imm_ok;
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign done      = (state == ST_DONE);

    // Gate the head entry so the outputs read zero whenever nothing is buffered.
    assign out_instr = fifo_empty ? 32'd0 : fifo_rdata[63:32];
    assign out_addr  = fifo_empty ? 32'd0 : fifo_rdata[31:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            addr        <= BASE_ADDR;
            instr_count <= '0;
            enc_error   <= 1'b0;
        end else begin
            enc_error <= accept && !imm_ok;
            if (push) begin
                addr <= addr + 32'd4;
            end
            if (pop) begin
                instr_count <= instr_count + 32'd1;
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        addr        <= BASE_ADDR;
                        instr_count <= '0;
                        state       <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (accept && in_last) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (fifo_empty) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    encoder_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FIFO_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata ({word, addr}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed and randomized bench for instruction_encoder; two instances
// (base 0 and base FFFF_FFFC) share stimulus and are checked against one model.
module tb_instruction_encoder;
    import riscv_encode_pkg::*;

    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE1 = 32'hFFFF_FFFC;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic        in_last;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_func3;
    logic [6:0]  in_func7;
    logic [31:0] in_imm;
    logic        out_ready;

    logic        in_ready0, in_ready1;
    logic        out_valid0, out_valid1;
    logic [31:0] out_instr0, out_instr1;
    logic [31:0] out_addr0, out_addr1;
    logic        enc_error0, enc_error1;
    logic        done0, done1;
    logic [31:0] instr_count0, instr_count1;

    instruction_encoder #(.FIFO_DEPTH(DEPTH), .BASE_ADDR(32'h0000_0000)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready0),
        .in_last(in_last), .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_func3(in_func3), .in_func7(in_func7),
        .in_imm(in_imm), .out_valid(out_valid0), .out_ready(out_ready),
        .out_instr(out_instr0), .out_addr(out_addr0), .enc_error(enc_error0),
        .done(done0), .instr_count(instr_count0));

    instruction_encoder #(.FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready1),
        .in_last(in_last), .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_func3(in_func3), .in_func7(in_func7),
        .in_imm(in_imm), .out_valid(out_valid1), .out_ready(out_ready),
        .out_instr(out_instr1), .out_addr(out_addr1), .enc_error(enc_error1),
        .done(done1), .instr_count(instr_count1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] q_word[$];
    logic [31:0] q_off[$];
    logic [31:0] exp_off;
    logic [31:0] exp_count;
    bit          loading;
    bit          err_due;
    bit          rand_mode;
    bit          last_acc;
    int          n_vec;
    int          n_err;

    logic [6:0] ops [7];
    int         blist [14];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference encoding: field values shifted into place, immediate legality by integer range.
    function automatic bit model_enc(input logic [2:0] fmt, input logic [6:0] op,
                                     input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [4:0] rs2, input logic [2:0] f3,
                                     input logic [6:0] f7, input logic [31:0] imm,
                                     output logic [31:0] w);
        int s;
        bit ok;
        s  = $signed(imm);
        w  = 32'(op);
        ok = 1'b0;
        case (fmt)
            3'd0: begin
                ok = 1'b1;
                w = w | (32'(rd) << 7) | (32'(f3) << 12) | (32'(rs1) << 15)
                      | (32'(rs2) << 20) | (32'(f7) << 25);
            end
            3'd1: begin
                ok = (s >= -2048) && (s <= 2047);
                w = w | (32'(rd) << 7) | (32'(f3) << 12) | (32'(rs1) << 15)
                      | ((imm & 32'hFFF) << 20);
            end
            3'd2: begin
                ok = (s >= -2048) && (s <= 2047);
                w = w | ((imm & 32'h1F) << 7) | (32'(f3) << 12) | (32'(rs1) << 15)
                      | (32'(rs2) << 20) | (((imm >> 5) & 32'h7F) << 25);
            end
            3'd3: begin
                ok = (s >= -4096) && (s <= 4094) && ((imm & 32'h1) == 0);
                w = w | (((imm >> 11) & 32'h1) << 7) | (((imm >> 1) & 32'hF) << 8)
                      | (32'(f3) << 12) | (32'(rs1) << 15) | (32'(rs2) << 20)
                      | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 12) & 32'h1) << 31);
            end
            3'd4: begin
                ok = ((imm & 32'hFFF) == 0);
                w = w | (32'(rd) << 7) | (imm & 32'hFFFF_F000);
            end
            3'd5: begin
                ok = (s >= -1048576) && (s <= 1048574) && ((imm & 32'h1) == 0);
                w = w | (32'(rd) << 7) | (((imm >> 12) & 32'hFF) << 12)
                      | (((imm >> 11) & 32'h1) << 20) | (((imm >> 1) & 32'h3FF) << 21)
                      | (((imm >> 20) & 32'h1) << 31);
            end
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // One clock: check outputs against the model at the falling edge, then advance.
    task automatic cycle();
        int          occ;
        bit          popped;
        bit          ok;
        logic [31:0] w;
        @(negedge clk);
        occ    = q_word.size();
        popped = 1'b0;
        check("out_valid", 32'(out_valid0), 32'(occ != 0));
        check("out_valid_b", 32'(out_valid1), 32'(occ != 0));
        if (occ != 0 && out_valid0) begin
            check("out_instr", out_instr0, q_word[0]);
            check("out_addr", out_addr0, q_off[0]);
            check("out_instr_b", out_instr1, q_word[0]);
            check("out_addr_b", out_addr1, q_off[0] + BASE1);
            if (out_ready) begin
                void'(q_word.pop_front());
                void'(q_off.pop_front());
                popped = 1'b1;
            end
        end
        check("in_ready", 32'(in_ready0), 32'(loading && (occ < DEPTH)));
        check("in_ready_b", 32'(in_ready1), 32'(loading && (occ < DEPTH)));
        check("instr_count", instr_count0, exp_count);
        check("instr_count_b", instr_count1, exp_count);
        check("enc_error", 32'(enc_error0), 32'(err_due));
        check("enc_error_b", 32'(enc_error1), 32'(err_due));
        err_due = 1'b0;
        if (popped) exp_count = exp_count + 32'd1;
        last_acc = in_valid && in_ready0;
        if (last_acc) begin
            ok = model_enc(in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_func3, in_func7, in_imm, w);
            if (ok) begin
                q_word.push_back(w);
                q_off.push_back(exp_off);
                exp_off = exp_off + 32'd4;
            end else begin
                err_due = 1'b1;
            end
            if (in_last) loading = 1'b0;
        end
        @(posedge clk);
        #1;
        if (last_acc) begin
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
        if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm, input logic last);
        int n;
        n         = 0;
        in_fmt    = fmt;
        in_opcode = op;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_func3  = f3;
        in_func7  = f7;
        in_imm    = imm;
        in_last   = last;
        in_valid  = 1'b1;
        last_acc  = 1'b0;
        while (!last_acc && n < 60) begin
            cycle();
            n++;
        end
        check("send_accept", 32'(last_acc), 32'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic start_prog();
        start = 1'b1;
        cycle();
        start     = 1'b0;
        loading   = 1'b1;
        exp_off   = 32'd0;
        exp_count = 32'd0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done0 !== 1'b1 && n < 200) begin
            cycle();
            n++;
        end
        check(tag, 32'(done0), 32'd1);
        check({tag, "_b"}, 32'(done1), 32'd1);
        check({tag, "_drained"}, q_word.size(), 32'd0);
        cycle();
        check({tag, "_pulse"}, 32'(done0), 32'd0);
    endtask

    task automatic model_reset();
        q_word.delete();
        q_off.delete();
        exp_off   = 32'd0;
        exp_count = 32'd0;
        loading   = 1'b0;
        err_due   = 1'b0;
    endtask

    initial begin
        logic [2:0]  f;
        logic [31:0] imm;
        n_vec = 0;
        n_err = 0;
        rand_mode = 1'b0;
        ops   = '{OP_IMM, OP_REG, OP_BRANCH, OP_JAL, OP_LUI, OP_STORE, OP_LOAD};
        blist = '{-2048, 2047, -2049, 2048, -4096, 4094, 4096, -4098, 4093,
                  -1048576, 1048574, 1048576, -1048578, 3};
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_fmt = 3'd0;
        in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_func3 = '0;
        in_func7 = '0; in_imm = '0; out_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready0), 32'd0);
        check("rst_out_valid", 32'(out_valid0), 32'd0);
        check("rst_out_instr", out_instr0, 32'd0);
        check("rst_out_addr", out_addr1, 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        check("rst_enc_error", 32'(enc_error0), 32'd0);
        check("rst_instr_count", instr_count0, 32'd0);
        rst_n = 1'b1;
        cycle();

        // Single I-type program
        out_ready = 1'b1;
        start_prog();
        send(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1);
        check("addi_latency", 32'(out_valid0), 32'd1);
        check("addi_instr", out_instr0, 32'h0050_0093);
        check("addi_addr", out_addr0, 32'h0000_0000);
        wait_done("addi_done");
        check("idle_in_ready", 32'(in_ready0), 32'd0);

        // R then B, also covering the wrapping base on dut1
        start_prog();
        send(FMT_R, OP_REG, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0);
        check("add_instr", out_instr0, 32'h0020_81B3);
        check("add_addr", out_addr0, 32'h0000_0000);
        check("add_addr_wrapbase", out_addr1, 32'hFFFF_FFFC);
        send(FMT_B, OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 1'b1);
        check("beq_instr", out_instr0, 32'hFE00_0EE3);
        check("beq_addr", out_addr0, 32'h0000_0004);
        check("beq_addr_wrapped", out_addr1, 32'h0000_0000);
        wait_done("rb_done");

        // J accepted, J rejected (odd offset), then U keeps the next address
        start_prog();
        send(FMT_J, OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b0);
        check("jal_instr", out_instr0, 32'h0010_00EF);
        send(FMT_J, OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 1'b0);
        check("jal_odd_error", 32'(enc_error0), 32'd1);
        check("jal_odd_no_word", 32'(out_valid0), 32'd0);
        send(FMT_U, OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 1'b1);
        check("lui_instr", out_instr0, 32'h1234_52B7);
        check("lui_addr", out_addr0, 32'h0000_0004);
        wait_done("j_done");

        // Backpressure: four words fill the buffer, fifth waits
        start_prog();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            send(FMT_I, OP_IMM, 5'(i + 1), 5'(i), 5'd0, 3'd0, 7'd0, 32'(i * 100), 1'b0);
        check("full_in_ready", 32'(in_ready0), 32'd0);
        check("full_held_addr", out_addr0, 32'd0);
        out_ready = 1'b1;
        send(FMT_I, OP_IMM, 5'd5, 5'd4, 5'd0, 3'd0, 7'd0, 32'd400, 1'b1);
        wait_done("bp_done");
        check("bp_count", instr_count0, 32'd5);

        // Reset with words buffered
        start_prog();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send(FMT_I, OP_IMM, 5'(i + 7), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i), 1'b0);
        check("pre_rst_valid", 32'(out_valid0), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", 32'(out_valid0), 32'd0);
        check("rst_mid_out_valid_b", 32'(out_valid1), 32'd0);
        check("rst_mid_in_ready", 32'(in_ready0), 32'd0);
        check("rst_mid_out_instr", out_instr0, 32'd0);
        check("rst_mid_out_addr", out_addr0, 32'd0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        cycle();
        cycle();
        check("rst_needs_start", 32'(in_ready0), 32'd0);
        out_ready = 1'b1;
        start_prog();
        send(FMT_S, OP_STORE, 5'd0, 5'd2, 5'd3, 3'd2, 7'd0, 32'hFFFF_FFF8, 1'b1);
        check("rst_restart_addr", out_addr0, 32'd0);
        check("rst_restart_addr_b", out_addr1, BASE1);
        wait_done("rst_done");

        // Randomized program with random backpressure
        rand_mode = 1'b1;
        start_prog();
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0) f = 3'($urandom_range(6, 7));
            else f = 3'($urandom_range(0, 5));
            case ($urandom_range(0, 3))
                0: imm = $urandom();
                1: imm = 32'($urandom_range(0, 10000)) - 32'd5000;
                2: imm = 32'(blist[$urandom_range(0, 13)]);
                default: imm = $urandom() & 32'hFFFF_F000;
            endcase
            send(f, ops[$urandom_range(0, 6)], 5'($urandom()), 5'($urandom()), 5'($urandom()),
                 3'($urandom()), 7'($urandom()), imm, 1'(i == 39));
        end
        wait_done("rand_done");
        rand_mode = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instruction_encoder.md
INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of encoded words buffered (power of two, at least 2).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the byte address assigned to the first word of a program.
REQ-003 SHALL have ports, in this order:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a new program.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept a bundle.
- in_last  in  1  final bundle of the program.
- in_fmt  in  3  format: R=0, I=1, S=2, B=3, U=4, J=5.
- in_opcode  in  7  opcode field.
- in_rd, in_rs1, in_rs2  in  5 each  register fields.
- in_func3  in  3  func3 field.
- in_func7  in  7  func7 field.
- in_imm  in  32  signed byte immediate.
- out_valid  out  1  encoded word valid.
- out_ready  in  1  downstream accepts the word.
- out_instr  out  32  encoded instruction.
- out_addr  out  32  byte address of out_instr.
- enc_error  out  1  one-cycle pulse: bundle rejected.
- done  out  1  one-cycle pulse: program drained.
- instr_count  out  32  words delivered since start.

Function
REQ-004 SHALL implement the FSM states IDLE, LOAD, DRAIN and DONE.
REQ-005 SHALL, in IDLE with start=1, clear the address pointer to BASE_ADDR and instr_count to 0 and go to LOAD; start SHALL be ignored in every other state.
REQ-006 SHALL drive in_ready = (state==LOAD) && FIFO not full; a bundle is accepted only when in_valid && in_ready.
REQ-007 SHALL, on an accepted bundle with in_last=1, go to DRAIN, regardless of whether that bundle is valid or rejected.
REQ-008 SHALL, in DRAIN, go to DONE when the FIFO is empty, hold done=1 for the single DONE cycle, then return to IDLE.
REQ-009 SHALL pack bits per the RV32I formats: opcode[6:0], rd[11:7], func3[14:12], rs1[19:15], rs2[24:20], func7[31:25], using the I/S/B/U/J immediate bit placements, with fields unused by the format driven to 0.
REQ-010 SHALL reject a bundle when any of the following holds:
- I or S format with imm outside -2048..2047;
- B format with imm outside -4096..4094 or imm[0]=1;
- J format with imm outside -1048576..1048574 or imm[0]=1;
- U format with imm[11:0] not 0;
- in_fmt greater than 5.
REQ-011 SHALL, for a rejected bundle, complete the handshake, write nothing to the FIFO, leave the address unchanged and pulse enc_error in the following cycle.
REQ-012 SHALL write a valid bundle's word together with the current address into the FIFO on the accept edge, then advance the address by 4, wrapping modulo 2^32.
REQ-013 SHALL give 1-cycle latency: out_valid is asserted the cycle after the accept edge when the FIFO was empty.
REQ-014 SHALL hold out_valid, out_instr and out_addr stable while out_valid && !out_ready.
REQ-015 SHALL increment instr_count by 1 on each out_valid && out_ready, wrapping at 2^32.
REQ-016 SHALL keep the occupancy unchanged on a simultaneous push and pop, which is legal whenever the FIFO is not full; a push when full is impossible because in_ready is 0.

Reset
REQ-017 SHALL, while rst_n=0, asynchronously force: state=IDLE, FIFO empty, address=BASE_ADDR, instr_count=0, in_ready=0, out_valid=0, enc_error=0, done=0, out_instr=0, out_addr=0.
REQ-018 SHALL discard buffered words on reset mid-program, and SHALL require a new start before accepting bundles.

Structure
REQ-019 SHALL take the format enum, opcode constants and the FIFO_DEPTH default from a shared package, riscv_encode_pkg.
REQ-020 SHALL implement buffering in a single sub-module, encoder_fifo (storing 64 bits: word plus address), with packing, range checking and the FSM in instruction_encoder.

Verification
REQ-021 SHALL cover: start; I, opcode 0010011, rd=1, rs1=0, func3=0, imm=5, last=1 -> out_instr=32'h0050_0093, out_addr=0, done pulses after the handshake.
REQ-022 SHALL cover: R, opcode 0110011, rd=3, rs1=1, rs2=2, func3=0, func7=0, then B, opcode 1100011, rs1=0, rs2=0, imm=-4 -> 32'h0020_81B3 @0, then 32'h FE00_0EE3 @4.
REQ-023 SHALL cover: J, opcode 1101111, rd=1, imm=2048 -> 32'h0010_00EF; J with imm=3 -> enc_error pulse, no word delivered, next word's address unchanged.
REQ-024 SHALL cover: out_ready=0 with 5 valid bundles offered -> in_ready drops after the 4th; releasing out_ready delivers all 5 in order, with addresses 0,4,8,12,16 and instr_count=5.
REQ-025 SHALL cover: rst_n pulsed low with 3 words buffered -> out_valid=0 immediately, and the subsequent program restarts at BASE_ADDR.
REQ-026 SHALL cover: BASE_ADDR=32'hFFFF_FFFC with two words -> addresses FFFF_FFFC, then 0000_0000.
